// File: rtl/mem_block_copier.sv
// Purpose: bus master that copies len words from src_addr to dst_addr in a single-port memory.
// Latency: 2+RD_LAT cycles per word; done is high len*(2+RD_LAT)+1 cycles after the accepting edge.
// Backpressure: the memory never stalls; start is ignored while busy.
// Ports: clk, reset (synchronous, active-low); start/src_addr/dst_addr/len request;
//        busy/done status; mem_read/mem_write/mem_addr/mem_wdata/mem_rdata memory port.
// Option: defining MEM_COPY_CHECKSUM_EN adds a checksum output (sum of written words, mod 2^DW).
module mem_block_copier #(
   parameter int AW     = 8,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
   ,
   output logic [DW-1:0] checksum
`endif
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, FIN} state_t;

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   idx_q, idx_d;
   logic [AW:0]   idx_inc;
   logic [1:0]    lat_q, lat_d;
   logic [DW-1:0] data_q, data_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
   logic [DW-1:0] csum_q, csum_d;
   assign checksum = csum_q;
`endif

   // idx is one bit wider than the address so len=256 terminates on idx==256, not on wrap to 0.
   assign idx_inc = idx_q + {{AW{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         lat_q   <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      idx_d     = idx_q;
      lat_d     = lat_q;
      data_d    = data_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
`ifdef MEM_COPY_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      busy      = 1'b0;
      done      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               src_d   = src_addr;
               dst_d   = dst_addr;
               len_d   = len;
               idx_d   = '0;
`ifdef MEM_COPY_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = (len == '0) ? FIN : RD_REQ;
            end
         end
         RD_REQ: begin
            busy     = 1'b1;
            mem_read = 1'b1;
            addr_d   = src_q + idx_q[AW-1:0];
            lat_d    = '0;
            state_d  = RD_WAIT;
         end
         RD_WAIT: begin
            busy = 1'b1;
            if (lat_q == LAT_LAST) begin
               data_d  = mem_rdata;
               state_d = WR;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         WR: begin
            busy      = 1'b1;
            mem_write = 1'b1;
            addr_d    = dst_q + idx_q[AW-1:0];
            wdata_d   = data_q;
            idx_d     = idx_inc;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_d    = csum_q + data_q;
`endif
            state_d   = (idx_inc == len_q) ? FIN : RD_REQ;
         end
         FIN: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Address/data are the registered copies outside strobe cycles, so they hold their last value.
      mem_addr  = addr_d;
      mem_wdata = wdata_d;
   end

endmodule

// File: tb/tb_mem_block_copier.sv
// Purpose: randomized + directed check of mem_block_copier against a word-by-word copy model.
// Latency: done cycle predicted as len*(2+RD_LAT) cycles after the first post-accept cycle.
// Backpressure: none; the memory model answers every read after RD_LAT edges.
module tb_mem_block_copier;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int RD_LAT = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start;
   logic [AW-1:0] src_addr, dst_addr;
   logic [AW:0]   len;
   logic          busy, done, mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   mem_block_copier #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_COPY_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   logic [DW-1:0] mem     [0:255];
   logic [DW-1:0] ref_mem [0:255];
   logic [DW-1:0] rd_pipe [0:2];
   assign mem_rdata = rd_pipe[RD_LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   typedef struct packed { logic [31:0] c; logic [DW-1:0] cs; } dn_t;
   wr_t           exp_wr[$];
   logic [AW-1:0] exp_rd[$];
   dn_t           exp_dn[$];

   int total = 0;
   int bad   = 0;
   int acc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
      mem[a]     = v;
      ref_mem[a] = v;
   endtask

   // Reference: a forward word-by-word copy; first n_rd reads and first n_wr writes are expected.
   task automatic expect_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input int n_rd, input int n_wr, output logic [DW-1:0] cs);
      logic [DW-1:0] v;
      cs = '0;
      for (int i = 0; i < n_rd; i++) begin
         exp_rd.push_back(8'(s + i));
         if (i < n_wr) begin
            v = ref_mem[8'(s + i)];
            ref_mem[8'(d + i)] = v;
            exp_wr.push_back({8'(d + i), v});
            cs = cs + v;
         end
      end
   endtask

   task automatic cmp_mem(input string nm);
      int nbad = 0;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== ref_mem[i]) nbad++;
      chk({nm, "_mem_diff_words"}, nbad, 0);
   endtask

   task automatic wait_idle(input string nm, input int lim);
      int k = 0;
      while (busy && k < lim) begin
         tick();
         k++;
      end
      chk({nm, "_busy_end"}, {31'd0, busy}, 0);
   endtask

   task automatic run_copy(input string nm, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW:0] n);
      logic [DW-1:0] cs;
      expect_copy(s, d, int'(n), int'(n), cs);
      start = 1'b1; src_addr = s; dst_addr = d; len = n;
      tick();
      start = 1'b0;
      exp_dn.push_back({32'(cyc + int'(n) * (2 + RD_LAT)), cs});
      wait_idle(nm, int'(n) * (2 + RD_LAT) + 10);
      chk({nm, "_done_pending"}, exp_dn.size(), 0);
      chk({nm, "_access_pending"}, exp_wr.size() + exp_rd.size(), 0);
      cmp_mem(nm);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, busy=%b", busy);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] cs;
      fork
         // Memory model: write at the edge, read data appears RD_LAT edges after the request.
         forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr] = mem_wdata;
            rd_pipe[0] <= mem_read ? mem[mem_addr] : 16'hDEAD;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         end
         // Monitor: pops expectations whenever the DUT strobes or signals done.
         forever begin
            wr_t w;
            dn_t e;
            @(negedge clk);
            if (mem_read || mem_write) begin
               total++;
               if ((mem_read && mem_write) || !busy || done) begin
                  bad++;
                  $display("FAIL strobe_proto: rd=%b wr=%b busy=%b done=%b, want one strobe inside a copy",
                           mem_read, mem_write, busy, done);
               end
            end
            if (mem_read) begin
               if (exp_rd.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_read: addr=%0h want no read", mem_addr);
               end else chk("rd_addr", mem_addr, exp_rd.pop_front());
            end
            if (mem_write) begin
               if (exp_wr.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_write: addr=%0h data=%0h want no write", mem_addr, mem_wdata);
               end else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", mem_addr, w.a);
                  chk("wr_data", mem_wdata, w.d);
               end
            end
            if (done) begin
               if (exp_dn.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_done: cycle=%0d want no done", cyc);
               end else begin
                  e = exp_dn.pop_front();
                  chk("done_cycle", cyc, e.c);
`ifdef MEM_COPY_CHECKSUM_EN
                  chk("done_checksum", checksum, e.cs);
`endif
               end
            end
         end
      join_none

      reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom));
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_strobes", {mem_read, mem_write}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      reset = 1'b1;
      tick();

      preload(8'h10, 16'h8888); preload(8'h11, 16'h1111); preload(8'h12, 16'hADAD);
      run_copy("basic", 8'h10, 8'h40, 9'd3);
      chk("basic_w0", mem[8'h40], 16'h8888);
      chk("basic_w1", mem[8'h41], 16'h1111);
      chk("basic_w2", mem[8'h42], 16'hADAD);

      run_copy("zero", 8'h06, 8'h08, 9'd0);

      preload(8'hFE, 16'hA0A0); preload(8'hFF, 16'hB1B1);
      preload(8'h00, 16'hC2C2); preload(8'h01, 16'hD3D3);
      run_copy("wrap", 8'hFE, 8'h20, 9'd4);
      chk("wrap_w0", mem[8'h20], 16'hA0A0);
      chk("wrap_w1", mem[8'h21], 16'hB1B1);
      chk("wrap_w2", mem[8'h22], 16'hC2C2);
      chk("wrap_w3", mem[8'h23], 16'hD3D3);

      preload(8'h30, 16'h0001); preload(8'h31, 16'h0002);
      run_copy("overlap", 8'h30, 8'h31, 9'd2);
      chk("overlap_31", mem[8'h31], 16'h0001);
      chk("overlap_32", mem[8'h32], 16'h0001);

      preload(8'h50, 16'hFFFF); preload(8'h51, 16'h0002); preload(8'h52, 16'h1234);
      run_copy("csum", 8'h50, 8'h60, 9'd3);
`ifdef MEM_COPY_CHECKSUM_EN
      chk("csum_value", checksum, 16'h1235);
      repeat (5) tick();
      chk("csum_held", checksum, 16'h1235);
`endif

      run_copy("same", 8'h70, 8'h70, 9'd5);
      run_copy("full", 8'h00, 8'h80, 9'd256);

      // Busy-ignore then mid-copy reset: reads 0..3 and writes 0..2 land before reset takes effect.
      expect_copy(8'h88, 8'hC8, 4, 3, cs);
      start = 1'b1; src_addr = 8'h88; dst_addr = 8'hC8; len = 9'd8;
      tick();
      start = 1'b0;
      acc = cyc;
      repeat (4) tick();
      start = 1'b1; src_addr = 8'h99; dst_addr = 8'h77; len = 9'd5;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("abort_cycle_align", cyc - acc, 10);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_strobes", {mem_read, mem_write}, 0);
`ifdef MEM_COPY_CHECKSUM_EN
      chk("abort_csum", checksum, 0);
`endif
      repeat (4) tick();
      chk("abort_idle_strobes", {busy, mem_read, mem_write}, 0);
      chk("abort_access_pending", exp_wr.size() + exp_rd.size(), 0);
      chk("abort_done_pending", exp_dn.size(), 0);
      cmp_mem("abort");

      for (int t = 0; t < 25; t++)
         run_copy("rand", 8'($urandom), 8'($urandom), 9'($urandom_range(0, 40)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
